// File: rtl/booth_seq_mul_if.sv
// Operand/product handshake bundle for the sequential Booth multiplier.
// The master side offers operands and consumes products; the slave side is the multiplier.
interface booth_seq_mul_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out1;
  logic           busy;

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out1, busy
  );

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out1, busy
  );
endinterface

// File: rtl/booth_seq_mul.sv
// Iterative signed radix-4 Booth multiplier: one recoded digit per clock,
// shifted partial products accumulated into a 2W-bit product behind valid/ready.
//
// state  | meaning
// IDLE   | waiting for an operand pair
// RUN    | processing digit cnt (0..N-1) of the recoded multiplier
// DONE   | product on out1, out_valid high until out_ready
module booth_seq_mul #(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          rst,
  booth_seq_mul_if.slave bus
);
  localparam int N  = W / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [W:0]     mreg;
  logic [W-1:0]   areg;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] out1_q;
  logic           out_valid_q;

  logic           accept;
  logic           last_digit;
  logic [2:0]     window;
  logic [W+1:0]   pp;
  logic [2*W-1:0] pp_ext;
  logic [2*W-1:0] acc_next;

  assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out1      = out1_q;
  assign bus.busy      = (state == S_RUN);

  assign accept     = bus.in_valid && bus.in_ready;
  assign last_digit = (cnt == CW'(N - 1));

  // mreg[0] is the appended guard bit, so digit cnt reads bits 2*cnt+1..2*cnt-1 of the multiplier
  assign window = mreg[{cnt, 1'b0} +: 3];

  // Two extra bits over A: -2A for the most negative A must still be positive
  always_comb begin
    pp = '0;
    case (window)
      3'b001, 3'b010: pp = {{2{areg[W-1]}}, areg};
      3'b011:         pp = {areg[W-1], areg, 1'b0};
      3'b100:         pp = -{areg[W-1], areg, 1'b0};
      3'b101, 3'b110: pp = -{{2{areg[W-1]}}, areg};
      default:        pp = '0;
    endcase
  end

  assign pp_ext   = {{(W - 2){pp[W+1]}}, pp};
  assign acc_next = acc + (pp_ext << {cnt, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mreg        <= '0;
      areg        <= '0;
      acc         <= '0;
      cnt         <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last_digit) begin
            state       <= S_DONE;
            out1_q      <= acc_next;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Accept only happens from IDLE or a completing DONE, so it overrides the return to IDLE
      if (accept) begin
        mreg  <= {bus.in1, 1'b0};
        areg  <= bus.in2;
        acc   <= '0;
        cnt   <= '0;
        state <= S_RUN;
      end
    end
  end

  a_valid_only_in_done: assert property (@(posedge clk) disable iff (rst)
    out_valid_q |-> (state == S_DONE));
  a_no_ready_while_run: assert property (@(posedge clk) disable iff (rst)
    (state == S_RUN) |-> !bus.in_ready);
endmodule
